// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IFU/LSU memory-port arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 64;
   localparam int DATA_W_DEF = 64;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
   typedef enum logic {OWN_IFU, OWN_LSU} owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter view, master = environment view.
interface mem_arbiter_if import mem_arb_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   logic                ifu_req_valid;
   logic [ADDR_W-1:0]   ifu_req_addr;
   logic                ifu_req_ready;
   logic                ifu_resp_valid;
   logic [DATA_W-1:0]   ifu_resp_data;

   logic                lsu_req_valid;
   logic [ADDR_W-1:0]   lsu_req_addr;
   logic                lsu_req_wen;
   logic [DATA_W-1:0]   lsu_req_wdata;
   logic [DATA_W/8-1:0] lsu_req_wmask;
   logic                lsu_req_ready;
   logic                lsu_resp_valid;
   logic [DATA_W-1:0]   lsu_resp_data;

   logic                mem_req_valid;
   logic                mem_req_ready;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_wen;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W/8-1:0] mem_wmask;
   logic                mem_resp_valid;
   logic [DATA_W-1:0]   mem_resp_data;

   modport slave (
      input  ifu_req_valid, ifu_req_addr,
      output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
      input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
      output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
      output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      input  mem_req_ready, mem_resp_valid, mem_resp_data
   );

   modport master (
      output ifu_req_valid, ifu_req_addr,
      input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
      output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
      input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
      input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      output mem_req_ready, mem_resp_valid, mem_resp_data
   );

endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin grant; combinational one-hot grant, last-grant flop updated on acceptance.
module arb_rr2 import mem_arb_pkg::*; (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,   // [0] IFU, [1] LSU
   input  logic       upd_i,
   output logic [1:0] gnt_o
);

   owner_e last_q, last_d;

   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = (last_q == OWN_IFU) ? 2'b10 : 2'b01;
         default: gnt_o = 2'b00;
      endcase
   end

   assign last_d = gnt_o[1] ? OWN_LSU : OWN_IFU;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= OWN_IFU;
      end else if (upd_i && (gnt_o != 2'b00)) begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction in flight, 3-cycle minimum latency.
// Requests stall (ready low) outside IDLE; responses are single-cycle pulses with no backpressure.
module mem_arbiter import mem_arb_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   localparam int MASK_W = DATA_W / 8;

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wen_q, wen_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [MASK_W-1:0]   wmask_q, wmask_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic [1:0] req, gnt;
   logic       accept;

   // Grant is only non-zero in IDLE, so a grant bit is both ready and transfer.
   assign req    = (state_q == IDLE) ? {bus.lsu_req_valid, bus.ifu_req_valid} : 2'b00;
   assign accept = (gnt != 2'b00);

   arb_rr2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i (req),
      .upd_i (accept),
      .gnt_o (gnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ISSUE;
         ISSUE:   if (bus.mem_req_ready) state_d = WAIT;
         WAIT:    if (bus.mem_resp_valid) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      owner_d = owner_q;
      addr_d  = addr_q;
      wen_d   = wen_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      rdata_d = rdata_q;
      if (accept) begin
         if (gnt[1]) begin
            owner_d = OWN_LSU;
            addr_d  = bus.lsu_req_addr;
            wen_d   = bus.lsu_req_wen;
            wdata_d = bus.lsu_req_wdata;
            wmask_d = bus.lsu_req_wmask;
         end else begin
            owner_d = OWN_IFU;
            addr_d  = bus.ifu_req_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
         end
      end
      if ((state_q == WAIT) && bus.mem_resp_valid) begin
         rdata_d = bus.mem_resp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= OWN_IFU;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
      end else begin
         owner_q <= owner_d;
         addr_q  <= addr_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      bus.ifu_req_ready  = gnt[0];
      bus.lsu_req_ready  = gnt[1];
      bus.mem_req_valid  = 1'b0;
      bus.mem_addr       = '0;
      bus.mem_wen        = 1'b0;
      bus.mem_wdata      = '0;
      bus.mem_wmask      = '0;
      bus.ifu_resp_valid = 1'b0;
      bus.ifu_resp_data  = '0;
      bus.lsu_resp_valid = 1'b0;
      bus.lsu_resp_data  = '0;
      case (state_q)
         ISSUE: begin
            bus.mem_req_valid = 1'b1;
            bus.mem_addr      = addr_q;
            bus.mem_wen       = wen_q;
            bus.mem_wdata     = wdata_q;
            bus.mem_wmask     = wmask_q;
         end
         DONE: begin
            if (owner_q == OWN_LSU) begin
               bus.lsu_resp_valid = 1'b1;
               bus.lsu_resp_data  = rdata_q;
            end else begin
               bus.ifu_resp_valid = 1'b1;
               bus.ifu_resp_data  = rdata_q;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected responses queued at acceptance, popped by a response monitor.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   logic rst;

   mem_arbiter_if bus ();

   mem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          lsu;
      logic [63:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_err    = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Any response pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      #2;
      if (bus.ifu_resp_valid === 1'b1 || bus.lsu_resp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_resp", {62'd0, bus.lsu_resp_valid, bus.ifu_resp_valid}, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("resp_owner", {62'd0, bus.lsu_resp_valid, bus.ifu_resp_valid},
                mon_e.lsu ? 64'd2 : 64'd1);
            chk("resp_data", mon_e.lsu ? bus.lsu_resp_data : bus.ifu_resp_data, mon_e.data);
         end
      end
   end

   task automatic chk_idle_outs(input string nm);
      chk({nm, "_ctl"}, {59'd0, bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid,
                         bus.ifu_req_ready, bus.lsu_req_ready}, 64'd0);
      chk({nm, "_maddr"}, bus.mem_addr, 64'd0);
      chk({nm, "_rdata"}, bus.ifu_resp_data | bus.lsu_resp_data, 64'd0);
   endtask

   // One transaction: drive requests, expect grant, optional issue stall, respond with rd.
   task automatic xact(input string nm, input bit no_sync,
                       input bit iv, input logic [63:0] ia,
                       input bit lv, input logic [63:0] la, input bit lw,
                       input logic [63:0] lwd, input logic [7:0] lm,
                       input bit exp_lsu, input int stall, input logic [63:0] rd,
                       input bit abort_in_wait);
      logic [63:0] e_addr;
      if (!no_sync) @(negedge clk);
      bus.mem_req_ready = 1'b0;
      bus.ifu_req_valid = iv;
      bus.ifu_req_addr  = ia;
      bus.lsu_req_valid = lv;
      bus.lsu_req_addr  = la;
      bus.lsu_req_wen   = lw;
      bus.lsu_req_wdata = lwd;
      bus.lsu_req_wmask = lm;
      #1;
      chk({nm, "_ifu_rdy"}, {63'd0, bus.ifu_req_ready}, {63'd0, !exp_lsu});
      chk({nm, "_lsu_rdy"}, {63'd0, bus.lsu_req_ready}, {63'd0, exp_lsu});
      chk({nm, "_idle_mvld"}, {63'd0, bus.mem_req_valid}, 64'd0);
      sb.push_back('{exp_lsu, rd});
      e_addr = exp_lsu ? la : ia;
      for (int k = 0; k <= stall; k++) begin
         @(negedge clk);
         if (k == 0) begin
            bus.mem_resp_valid = 1'b0;
            if (exp_lsu) begin
               bus.lsu_req_valid = 1'b0;
               bus.lsu_req_addr  = {$urandom, $urandom};
               bus.lsu_req_wdata = {$urandom, $urandom};
               bus.lsu_req_wmask = 8'($urandom);
               bus.lsu_req_wen   = ~lw;
            end else begin
               bus.ifu_req_valid = 1'b0;
               bus.ifu_req_addr  = {$urandom, $urandom};
            end
         end
         bus.mem_req_ready = (k == stall);
         #1;
         chk({nm, "_mvld"}, {63'd0, bus.mem_req_valid}, 64'd1);
         chk({nm, "_maddr"}, bus.mem_addr, e_addr);
         chk({nm, "_mwen"}, {63'd0, bus.mem_wen}, {63'd0, exp_lsu && lw});
         chk({nm, "_mwmask"}, {56'd0, bus.mem_wmask}, exp_lsu ? {56'd0, lm} : 64'd0);
         if (exp_lsu && lw) chk({nm, "_mwdata"}, bus.mem_wdata, lwd);
         chk({nm, "_busy_rdy"}, {62'd0, bus.ifu_req_ready, bus.lsu_req_ready}, 64'd0);
      end
      if (abort_in_wait) return;
      @(negedge clk);
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = rd;
      #1;
      chk({nm, "_wait_mvld"}, {63'd0, bus.mem_req_valid}, 64'd0);
      chk({nm, "_wait_maddr"}, bus.mem_addr, 64'd0);
      chk({nm, "_wait_resp"}, {62'd0, bus.ifu_resp_valid, bus.lsu_resp_valid}, 64'd0);
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = {$urandom, $urandom};
      #1;
      chk({nm, "_done_resp"}, {62'd0, bus.lsu_resp_valid, bus.ifu_resp_valid},
          exp_lsu ? 64'd2 : 64'd1);
      chk({nm, "_done_mvld"}, {63'd0, bus.mem_req_valid}, 64'd0);
      chk({nm, "_done_rdy"}, {62'd0, bus.ifu_req_ready, bus.lsu_req_ready}, 64'd0);
   endtask

   initial begin
      rst                = 1'b1;
      bus.ifu_req_valid  = 1'b0;
      bus.ifu_req_addr   = '0;
      bus.lsu_req_valid  = 1'b0;
      bus.lsu_req_addr   = '0;
      bus.lsu_req_wen    = 1'b0;
      bus.lsu_req_wdata  = '0;
      bus.lsu_req_wmask  = '0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;
      repeat (2) @(negedge clk);
      #1;
      chk_idle_outs("reset");
      rst = 1'b0;

      // Ties from reset: LSU first, then strict alternation.
      xact("tie0", 0, 1, 64'h8000_0004, 1, 64'h8000_1000, 0, 0, 8'h00, 1, 0, 64'h1111_2222_3333_4444, 0);
      xact("tie1", 0, 1, 64'h8000_0004, 1, 64'h8000_1008, 0, 0, 8'h00, 0, 0, 64'h0000_0000_0000_0013, 0);
      xact("tie2", 0, 1, 64'h8000_0008, 1, 64'h8000_1008, 0, 0, 8'h00, 1, 0, 64'hA5A5_0000_5A5A_FFFF, 0);
      xact("tie3", 0, 1, 64'h8000_0008, 1, 64'h8000_1010, 0, 0, 8'h00, 0, 0, 64'h0000_0000_0000_0093, 0);

      xact("fetch", 0, 1, 64'h8000_0000, 0, 64'h0, 0, 0, 8'h00, 0, 0, 64'h0000_0000_0000_0013, 0);

      xact("store", 0, 0, 64'h0, 1, 64'h8000_2000, 1, 64'h0000_0000_DEAD_BEEF, 8'h0F, 1, 3, 64'h0, 0);

      // Response with nothing outstanding must not disturb anything.
      @(negedge clk);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 64'h0BAD_0BAD_0BAD_0BAD;
      #1;
      chk_idle_outs("spur0");
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      #1;
      chk_idle_outs("spur1");

      // Lone LSU load reaches WAIT, then reset drops it.
      xact("rst_ld", 0, 0, 64'h0, 1, 64'h8000_3000, 0, 0, 8'h00, 1, 0, 64'h5555_5555_5555_5555, 1);
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_wait_mvld", {63'd0, bus.mem_req_valid}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      void'(sb.pop_back());
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 64'h5555_5555_5555_5555;
      #1;
      chk_idle_outs("post_rst");
      xact("post_rst_tie", 1, 1, 64'h8000_0100, 1, 64'h8000_4000, 0, 0, 8'h00, 1, 0, 64'h7777_8888_9999_AAAA, 0);

      repeat (3) @(negedge clk);
      #3;
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
